// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST sequencer.
// Configuration macro used by the top level: BIST_ABORT_EN.
package gate_bist_pkg;

  localparam int unsigned NUM_PATTERNS_DEF = 256;
  localparam int unsigned SETTLE_DEF       = 2;
  localparam int unsigned PRPG_W_DEF       = 20;
  localparam int unsigned MISR_W_DEF       = 10;

  // Primitive-polynomial taps: PRPG uses bits 19 and 16, MISR uses bits 9 and 6.
  localparam logic [19:0] PRPG_TAPS = 20'h90000;
  localparam logic [9:0]  MISR_TAPS = 10'h240;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    WAIT,
    CAPTURE,
    DONE
  } state_e;

  function automatic logic is_run_state(state_e s);
    return (s == SEED) || (s == WAIT) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR with synchronous load, step enable and a parallel XOR input.
// With xin tied to zero it is a pattern generator; with xin driven it is a MISR.
module bist_lfsr #(
  parameter int unsigned   W    = 20,
  parameter logic [W-1:0]  TAPS = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] xin,
  output logic [W-1:0] q
);

  logic         feedback;
  logic [W-1:0] q_next;

  always_comb begin
    feedback = ^(q & TAPS);
    q_next   = {q[W-2:0], feedback} ^ xin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/gate_bist_sequencer.sv
// BIST sequencer: PRPG vectors into a gate model, MISR compaction, golden compare.
// Optional abort input/aborted output enabled by defining BIST_ABORT_EN.
module gate_bist_sequencer
  import gate_bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = NUM_PATTERNS_DEF,
  parameter int unsigned SETTLE       = SETTLE_DEF,
  parameter int unsigned PRPG_W       = PRPG_W_DEF,
  parameter int unsigned MISR_W       = MISR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PRPG_W-1:0] seed,
  input  logic [MISR_W-1:0] golden,
  output logic [PRPG_W-1:0] dut_in,
  input  logic [MISR_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] sig
`ifdef BIST_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  localparam int unsigned     CNT_W       = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        wcnt;
  logic [PRPG_W-1:0] seed_nz;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              run_aborted;

  // A zero seed would lock the PRPG at zero forever.
  assign seed_nz   = (seed == '0) ? PRPG_W'(1) : seed;
  assign lfsr_load = (state == SEED);
  assign lfsr_step = (state == CAPTURE);

`ifdef BIST_ABORT_EN
  assign run_aborted = aborted;
`else
  assign run_aborted = 1'b0;
`endif

  bist_lfsr #(
    .W    (PRPG_W),
    .TAPS (PRPG_TAPS)
  ) u_prpg (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .en       (lfsr_step),
    .load_val (seed_nz),
    .xin      ('0),
    .q        (dut_in)
  );

  bist_lfsr #(
    .W    (MISR_W),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .en       (lfsr_step),
    .load_val ('0),
    .xin      (dut_out),
    .q        (sig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
`ifdef BIST_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SEED;
            busy  <= 1'b1;
          end
        end
        SEED: begin
          cnt   <= '0;
          wcnt  <= '0;
          pass  <= 1'b0;
`ifdef BIST_ABORT_EN
          aborted <= 1'b0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt == SETTLE_LAST) begin
            wcnt  <= '0;
            state <= CAPTURE;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        CAPTURE: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_ONE;
            state <= WAIT;
          end
        end
        DONE: begin
          pass  <= (sig == golden) && !run_aborted;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef BIST_ABORT_EN
      // Placed after the case so abort overrides the CAPTURE completion check.
      if (abort && is_run_state(state)) begin
        state   <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        aborted <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Scoreboard bench for gate_bist_sequencer: random runs against a behavioural model.
// Covers the BIST_ABORT_EN abort path when that macro is defined.
module tb_gate_bist_sequencer;

  localparam int NP = 3;
  localparam int ST = 2;
  localparam int LATENCY = 2 + NP * (ST + 1);

  typedef struct {
    int          start_cyc;
    logic [9:0]  sig;
    logic [19:0] din;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] seed_r = '0;
  logic [9:0]  golden_r = '0;
  logic [19:0] dut_in;
  logic [9:0]  dut_out;
  logic        busy, done, pass;
  logic [9:0]  sig;
  logic [9:0]  key = '0;
  bit          cmode = 1'b0;
  bit          abort_run = 1'b0;
`ifdef BIST_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   pass_pend = 1'b0;
  logic pend_pass = 1'b0;

  function automatic logic [9:0] gate_fn(logic [19:0] p, logic [9:0] k, bit cm);
    return cm ? k : (p[9:0] ^ {p[13:10], p[19:14]} ^ k);
  endfunction

  assign dut_out = gate_fn(dut_in, key, cmode);

  gate_bist_sequencer #(
    .NUM_PATTERNS (NP),
    .SETTLE       (ST),
    .PRPG_W       (20),
    .MISR_W       (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed    (seed_r),
    .golden  (golden_r),
    .dut_in  (dut_in),
    .dut_out (dut_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .sig     (sig)
`ifdef BIST_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: apply the stated PRPG/MISR recurrences NP times from the seed.
  task automatic model(input logic [19:0] s, input logic [9:0] k, input bit cm,
                       output logic [9:0] m, output logic [19:0] p);
    logic [9:0] o;
    p = (s == 20'd0) ? 20'd1 : s;
    m = '0;
    for (int i = 0; i < NP; i++) begin
      o = gate_fn(p, k, cm);
      m = (((m << 1) & 10'h3ff) | 10'(m[9] ^ m[6])) ^ o;
      p = ((p << 1) & 20'hfffff) | 20'(p[19] ^ p[16]);
    end
  endtask

  task automatic run(input logic [19:0] s, input bit cm, input bit match);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    cmode = cm;
    key   = cm ? 10'h001 : 10'($urandom);
    seed_r = s;
    model(s, key, cm, e.sig, e.din);
    golden_r  = match ? e.sig : 10'($urandom);
    e.pass    = (golden_r == e.sig);
    e.start_cyc = cyc;
    q.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("first_vector", 32'(dut_in), (s == 20'd0) ? 32'd1 : 32'(s));
`ifdef BIST_ABORT_EN
    chk("aborted_cleared", 32'(aborted), 32'd0);
`endif
    n = 0;
    while (!done && n < 200) begin
      start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      n++;
    end
    chk("run_completes", 32'(done), 32'd1);
    start = 1'(($urandom_range(0, 1)));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_sig"}, 32'(sig), 32'd0);
    chk({tag, "_dut_in"}, 32'(dut_in), 32'd0);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (pass_pend) begin
        chk("pass", 32'(pass), 32'(pend_pass));
        pass_pend = 1'b0;
      end
      if (done && !abort_run) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", 32'(cyc - e.start_cyc), 32'(LATENCY));
          chk("sig", 32'(sig), 32'(e.sig));
          chk("dut_in_final", 32'(dut_in), 32'(e.din));
          chk("busy_in_done", 32'(busy), 32'd0);
          chk("pass_low_in_done", 32'(pass), 32'd0);
          pend_pass = e.pass;
          pass_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run(20'd0, 1'b1, 1'b1);
    run(20'd1, 1'b1, 1'b0);
    run(20'd1, 1'b1, 1'b1);

    // Mid-run reset: outputs clear immediately, no done pulse follows.
    @(posedge clk); #1;
    seed_r = 20'h5a5a5;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done), 32'd0);

`ifdef BIST_ABORT_EN
    @(posedge clk); #1;
    abort_run = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_pass", 32'(pass), 32'd0);
    @(posedge clk); #1;
    chk("abort_pass_after", 32'(pass), 32'd0);
    chk("abort_flag_held", 32'(aborted), 32'd1);
    abort_run = 1'b0;
`endif

    for (int i = 0; i < 16; i++) begin
      run(20'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
